light_input_ctrl: RTL and testbench
===================================

# light_input_ctrl

Front-end input controller for the traffic-light datapath. It takes the four raw push-buttons (start, main-road block, side-road block, pause) and synchronizes and debounces them. It turns their presses into a registered operating mode, then drives clean, glitch-free, mutually consistent `start`/`stopa`/`stopb`/`pause` levels into the light sequencer. It is the producer side of the sequencer's control interface: the sequencer only ever sees settled levels, never raw pad signals.

## Interface

Parameters:
- `DB_CYCLES`, default 250000: consecutive stable `clk` cycles required before a button level is accepted (10 ms at 25 MHz). Must be ≥ 2.
- `CW`, default 18: debounce counter width. Must satisfy 2^CW > DB_CYCLES.

Ports:
- `clk`  in  1: system clock; the only clock.
- `clr`  in  1: reset. Synchronous and active-high.
- `btn_start`  in  1: raw start button, asynchronous, active-high.
- `btn_stopa`  in  1: raw main-road-blocked button, asynchronous.
- `btn_stopb`  in  1: raw side-road-blocked button, asynchronous.
- `btn_pause`  in  1: raw pause button, asynchronous.
- `start`  out  1: run level to the sequencer.
- `stopa`  out  1: main-road hold level.
- `stopb`  out  1: side-road hold level.
- `pause`  out  1: freeze level.
- `mode`  out  3: current state encoding. IDLE=0, RUN=1, PAUSED=2, HOLD_A=3, HOLD_B=4.
- `press`  out  4: one-cycle press pulses for debug and bench use, ordered `{pause,stopb,stopa,start}`.

## Operation

- **Synchronizer.** Each raw input passes through two flops. Both flops reset to 0.
- **Debounce (per button).** Each button has a counter `cnt` and a level `stable`.
  - If synced ≠ `stable`: `cnt` increments.
  - When `cnt` = DB_CYCLES−1 and the next cycle still differs: `stable` takes the synced value and `cnt` is cleared to 0.
  - Any cycle with synced = `stable` clears `cnt`.
  - Result: `stable` changes only after exactly DB_CYCLES consecutive differing synced samples. Rise and fall are symmetric. The counter never wraps.
- **Edge detect.** `press[i]` is registered and high for exactly one cycle after a 0→1 change of `stable[i]`. A release produces no pulse.
- **Mode FSM.** Transitions are evaluated on `press`. If several pulses occur in the same cycle, only the highest-priority one acts: stopa > stopb > pause > start.
  - stopa press: any state → HOLD_A, except HOLD_A → RUN (second press releases the hold).
  - stopb press: any state → HOLD_B, except HOLD_B → RUN.
  - pause press: RUN → PAUSED and PAUSED → RUN. Ignored in IDLE, HOLD_A and HOLD_B.
  - start press: IDLE → RUN, RUN → IDLE, PAUSED → IDLE. Ignored in HOLD_A and HOLD_B.
- **Outputs.** Outputs are registered and decoded from the next state, so they change on the same edge as `mode`.
  - IDLE: all levels 0.
  - RUN: `start`=1.
  - PAUSED: `start`=1, `pause`=1.
  - HOLD_A: `stopa`=1.
  - HOLD_B: `stopb`=1.
  - `stopa` and `stopb` are never both 1. No other output combination is legal.
- **Reset.** `clr` is sampled on the `clk` edge. It clears the sync flops, `stable`, `cnt`, `press`, `mode` (to IDLE) and all level outputs to 0. `clr` dominates any coincident press. A button held through reset must be released and debounced again before it can generate a new press.

## Timing

- Raw rising edge first sampled at edge t:
  - `stable` updates at t+1+DB_CYCLES.
  - `press` is high during the cycle after edge t+2+DB_CYCLES.
  - `mode` and level outputs update at edge t+3+DB_CYCLES.
- A pulse shorter than DB_CYCLES synced cycles is fully rejected: no `press`, no mode change.
- Bounce during the count restarts the count from 0.
- Holding a button produces exactly one `press`. Re-pressing requires a debounced release first.
- Minimum spacing between two accepted presses of the same button is 2·DB_CYCLES cycles.
- All outputs are glitch-free, with at most one change per mode transition.

## Test plan

All scenarios use DB_CYCLES=4.

1. Reset, then hold `btn_start` high for 20 cycles → `press[0]` pulses once, `mode` goes 0→1, and `start`=1 exactly 7 edges after the first sampled high. Release, then wait → no change.
2. 3-cycle glitch on `btn_pause` while in RUN → no `press[3]` and `mode` stays 1. A 10-cycle press → `mode`=2 with `start`=1 and `pause`=1. A second press → `mode`=1.
3. From RUN, press `btn_stopa` → `mode`=3, `stopa`=1, `start`=0. Press `btn_start` → ignored. Press `btn_stopa` again → `mode`=1.
4. `btn_stopa` and `btn_stopb` rising in the same cycle from IDLE → `mode`=3 only, `stopb`=0. After both release, press `btn_stopb` → `mode`=4 with `stopa`=0.
5. Bouncing `btn_start` (1,0,1,1,0,1,1,1,1,1,…) → exactly one `press[0]`, timed from the last 0→1 synced transition.
6. Assert `clr` for one cycle in HOLD_B while `btn_pause` is mid-debounce → next cycle all outputs are 0 and `mode`=0. With `btn_pause` still held, no `press[3]` appears until it is released and pressed again.

Source files
------------

// File: rtl/light_input_ctrl.sv
// light_input_ctrl
//   Front-end for the traffic-light sequencer. Synchronizes and debounces the four raw
//   push-buttons, turns debounced presses into a registered operating mode and drives
//   settled start/stopa/stopb/pause levels into the sequencer.
//
// Parameters
//   DB_CYCLES : consecutive stable synced cycles before a button level is accepted (>= 2)
//   CW        : debounce counter width, 2**CW > DB_CYCLES
//
// Ports
//   clk                      : system clock
//   clr                      : synchronous active-high reset
//   btn_start/stopa/stopb/pause : raw asynchronous active-high buttons
//   start, stopa, stopb, pause  : registered level outputs to the sequencer
//   mode                     : IDLE=0, RUN=1, PAUSED=2, HOLD_A=3, HOLD_B=4
//   press                    : one-cycle press pulses {pause, stopb, stopa, start}
module light_input_ctrl #(
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned CW        = 18
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_stopa,
    input  logic       btn_stopb,
    input  logic       btn_pause,
    output logic       start,
    output logic       stopa,
    output logic       stopb,
    output logic       pause,
    output logic [2:0] mode,
    output logic [3:0] press
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StPaused = 3'd2,
        StHoldA  = 3'd3,
        StHoldB  = 3'd4
    } mode_e;

    localparam logic [CW-1:0] CntLast = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    // Button bit order matches press: {pause, stopb, stopa, start}
    logic [3:0] raw;
    assign raw = {btn_pause, btn_stopb, btn_stopa, btn_start};

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    stable_dly_q;
    logic [3:0]    armed_q, armed_d;
    logic [3:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [CW-1:0] arm_cnt_q [4];
    logic [CW-1:0] arm_cnt_d [4];

    mode_e mode_q, mode_d;
    logic  start_d, stopa_d, stopb_d, pause_d;

    // Debounce and press arming.
    // A button comes out of reset disarmed: it may only produce a press after a debounced
    // low has been seen, either DB_CYCLES synced low samples in a row or a debounced
    // release. That keeps a button held through reset from firing once it re-debounces high.
    always_comb begin
        stable_d = stable_q;
        armed_d  = armed_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i]     = '0;
            arm_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
            if (!armed_q[i]) begin
                if (stable_q[i] && !stable_d[i]) begin
                    armed_d[i] = 1'b1;
                end else if (!stable_q[i] && !sync2_q[i]) begin
                    if (arm_cnt_q[i] == CntLast) begin
                        armed_d[i] = 1'b1;
                    end else begin
                        arm_cnt_d[i] = arm_cnt_q[i] + CntOne;
                    end
                end
            end
        end
        // Rising edge of the debounced level only; releases never pulse.
        press_d = armed_q & stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            armed_q      <= '0;
            press_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]     <= '0;
                arm_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            armed_q      <= armed_d;
            press_q      <= press_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]     <= cnt_d[i];
                arm_cnt_q[i] <= arm_cnt_d[i];
            end
        end
    end

    // Mode next state. Priority stopa > stopb > pause > start.
    always_comb begin
        mode_d = mode_q;
        if (press_q[1]) begin
            mode_d = (mode_q == StHoldA) ? StRun : StHoldA;
        end else if (press_q[2]) begin
            mode_d = (mode_q == StHoldB) ? StRun : StHoldB;
        end else if (press_q[3]) begin
            case (mode_q)
                StRun:    mode_d = StPaused;
                StPaused: mode_d = StRun;
                default:  mode_d = mode_q;
            endcase
        end else if (press_q[0]) begin
            case (mode_q)
                StIdle:   mode_d = StRun;
                StRun:    mode_d = StIdle;
                StPaused: mode_d = StIdle;
                default:  mode_d = mode_q;
            endcase
        end
        // Unreachable encodings recover to IDLE.
        if (mode_q > StHoldB) begin
            mode_d = StIdle;
        end

        // Levels are decoded from the next state so they register on the same edge as mode.
        start_d = 1'b0;
        stopa_d = 1'b0;
        stopb_d = 1'b0;
        pause_d = 1'b0;
        case (mode_d)
            StRun: start_d = 1'b1;
            StPaused: begin
                start_d = 1'b1;
                pause_d = 1'b1;
            end
            StHoldA: stopa_d = 1'b1;
            StHoldB: stopb_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mode_q <= StIdle;
            start  <= 1'b0;
            stopa  <= 1'b0;
            stopb  <= 1'b0;
            pause  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            start  <= start_d;
            stopa  <= stopa_d;
            stopb  <= stopb_d;
            pause  <= pause_d;
        end
    end

    assign mode  = mode_q;
    assign press = press_q;

endmodule

// File: tb/tb_light_input_ctrl.sv
// Self-checking bench for light_input_ctrl with DB_CYCLES=4. A behavioural model tracks
// each button as a window of recent synced samples and derives mode/levels from a
// transition table; a compare process checks every cycle, and directed scenarios add
// literal expectations.
module tb_light_input_ctrl;

    localparam int unsigned DB = 4;
    localparam logic [7:0]  WMASK = 8'h0F;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] btn;   // {pause, stopb, stopa, start}
    logic       start, stopa, stopb, pause;
    logic [2:0] mode;
    logic [3:0] press;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    light_input_ctrl #(
        .DB_CYCLES(DB),
        .CW       (3)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_start(btn[0]),
        .btn_stopa(btn[1]),
        .btn_stopb(btn[2]),
        .btn_pause(btn[3]),
        .start    (start),
        .stopa    (stopa),
        .stopb    (stopb),
        .pause    (pause),
        .mode     (mode),
        .press    (press)
    );

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [2:0] next_mode(input logic [2:0] m, input logic [3:0] p);
        if (p[1]) return (m == 3'd3) ? 3'd1 : 3'd3;
        if (p[2]) return (m == 3'd4) ? 3'd1 : 3'd4;
        if (p[3]) begin
            if (m == 3'd1) return 3'd2;
            if (m == 3'd2) return 3'd1;
            return m;
        end
        if (p[0]) begin
            if (m == 3'd0) return 3'd1;
            if (m == 3'd1 || m == 3'd2) return 3'd0;
            return m;
        end
        return m;
    endfunction

    // Returns {pause, stopb, stopa, start}
    function automatic logic [3:0] levels(input logic [2:0] m);
        case (m)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b1001;
            3'd3:    return 4'b0010;
            3'd4:    return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    logic [3:0] m_s1, m_s2, m_st, m_armed, m_pend, m_press;
    logic [7:0] m_hist [4];
    int         m_n [4];
    logic [2:0] m_mode;
    bit         chk_en = 0;

    always @(posedge clk) begin
        if (clr) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_armed = '0; m_pend = '0; m_press = '0;
            m_mode = 3'd0;
            for (int b = 0; b < 4; b++) begin
                m_hist[b] = '0;
                m_n[b]    = 0;
            end
        end else begin
            logic [3:0] new_press;
            m_mode = next_mode(m_mode, m_press);
            for (int b = 0; b < 4; b++) begin
                logic samp, old;
                logic [7:0] win;
                samp = m_s2[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = btn[b];
                m_hist[b] = {m_hist[b][6:0], samp};
                if (m_n[b] < 1000) m_n[b]++;
                old = m_st[b];
                win = m_hist[b] & WMASK;
                // Level flips once the last DB synced samples all disagree with it.
                if (m_n[b] >= int'(DB) && (old ? (win == 8'h00) : (win == WMASK)))
                    m_st[b] = ~old;
                new_press[b] = m_pend[b];
                m_pend[b] = m_armed[b] && !old && m_st[b];
                if (!m_armed[b] && ((old && !m_st[b]) ||
                                    (!old && m_n[b] >= int'(DB) && win == 8'h00)))
                    m_armed[b] = 1'b1;
            end
            m_press = new_press;
        end
    end

    // ---------------- per-cycle compare ----------------
    int unsigned press_cnt [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) if (press[b]) press_cnt[b]++;
        if (chk_en) begin
            check("mode", int'(mode), int'(m_mode));
            check("press", int'(press), int'(m_press));
            check("levels", int'({pause, stopb, stopa, start}), int'(levels(m_mode)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int b, input int len);
        btn[b] = 1'b1;
        cyc(len);
        btn[b] = 1'b0;
        cyc(15);
    endtask

    int unsigned c0, c3;
    int          hold [4];

    initial begin
        clr = 1'b1;
        btn = '0;
        cyc(3);
        chk_en = 1;
        check("reset_mode", int'(mode), 0);
        check("reset_levels", int'({pause, stopb, stopa, start}), 0);
        clr = 1'b0;
        cyc(10);

        // 1: held start -> one press, start rises 8 edges after the drive (7 after first sample)
        c0 = press_cnt[0];
        btn[0] = 1'b1;
        cyc(7);
        check("s1_start_before", int'(start), 0);
        cyc(1);
        check("s1_start_at", int'(start), 1);
        check("s1_mode", int'(mode), 1);
        cyc(12);
        btn[0] = 1'b0;
        cyc(20);
        check("s1_one_press", int'(press_cnt[0] - c0), 1);
        check("s1_mode_after", int'(mode), 1);

        // 2: glitch rejected, then pause toggles
        c3 = press_cnt[3];
        tap(3, 3);
        check("s2_glitch_press", int'(press_cnt[3] - c3), 0);
        check("s2_glitch_mode", int'(mode), 1);
        tap(3, 10);
        check("s2_paused", int'(mode), 2);
        check("s2_pause_lvls", int'({pause, start}), 3);
        tap(3, 10);
        check("s2_resume", int'(mode), 1);

        // 3: hold A, start ignored, release hold
        tap(1, 10);
        check("s3_holda", int'(mode), 3);
        check("s3_holda_lvls", int'({stopa, start}), 2);
        tap(0, 10);
        check("s3_start_ign", int'(mode), 3);
        tap(1, 10);
        check("s3_release", int'(mode), 1);

        // 4: simultaneous stopa+stopb from IDLE
        tap(0, 10);
        check("s4_idle", int'(mode), 0);
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        cyc(10);
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        cyc(15);
        check("s4_prio", int'(mode), 3);
        check("s4_stopb", int'(stopb), 0);
        tap(2, 10);
        check("s4_holdb", int'(mode), 4);
        check("s4_stopa", int'(stopa), 0);

        // 5: bouncing start
        c0 = press_cnt[0];
        begin
            logic [11:0] pat;
            pat = 12'b1111_1110_1101;   // applied LSB first: 1,0,1,1,0,1,1,1,...
            for (int i = 0; i < 12; i++) begin
                btn[0] = pat[i];
                cyc(1);
            end
        end
        cyc(6);
        btn[0] = 1'b0;
        cyc(15);
        check("s5_one_press", int'(press_cnt[0] - c0), 1);

        // 6: clr during pause debounce in HOLD_B, pause held through reset
        c3 = press_cnt[3];
        btn[3] = 1'b1;
        cyc(3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("s6_mode", int'(mode), 0);
        check("s6_levels", int'({pause, stopb, stopa, start}), 0);
        check("s6_press", int'(press), 0);
        cyc(20);
        check("s6_no_press", int'(press_cnt[3] - c3), 0);
        btn[3] = 1'b0;
        cyc(15);
        tap(3, 10);
        check("s6_repress", int'(press_cnt[3] - c3), 1);
        check("s6_mode_idle", int'(mode), 0);

        // Random phase: per-button random hold lengths give both glitches and real presses.
        for (int b = 0; b < 4; b++) hold[b] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    btn[b]  = ($urandom_range(0, 2) == 0);
                    hold[b] = int'($urandom_range(1, 12));
                end
            end
            clr = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        clr = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
